multi_dataflow_tcdm_responder: RTL



---
 rtl/multi_dataflow_tcdm_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/multi_dataflow_tcdm_responder.sv
// multi_dataflow_tcdm_responder
// -----------------------------------------------------------------------------
// Behavioural TCDM slave used in place of the cluster interconnect. MP request
// ports are served from a word-interleaved memory of N_BANKS banks. Each bank
// has its own round-robin arbiter, and out-of-range requests share one extra
// virtual bank. Granted accesses answer exactly one cycle later. An optional
// injector withholds a port's grant for one cycle after every STALL_EVERY grants.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous clear of err_o, arbiter pointers, stall counters
//   tcdm_req        per-port request
//   tcdm_add        per-port byte address
//   tcdm_wen        per-port direction (1 = read, 0 = write)
//   tcdm_be         per-port byte enables
//   tcdm_data       per-port write data
//   tcdm_gnt        per-port grant (combinational)
//   tcdm_r_valid    per-port response valid, one cycle after the grant
//   tcdm_r_data     per-port read data (zero for writes and when idle)
//   err_o           sticky out-of-range access flag
`timescale 1ns/1ps
module multi_dataflow_tcdm_responder #(
    parameter int          MP          = 4,
    parameter int          N_BANKS     = 4,
    parameter int          BANK_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          STALL_EVERY = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [MP-1:0]        tcdm_req,
    input  logic [MP-1:0][31:0]  tcdm_add,
    input  logic [MP-1:0]        tcdm_wen,
    input  logic [MP-1:0][3:0]   tcdm_be,
    input  logic [MP-1:0][31:0]  tcdm_data,
    output logic [MP-1:0]        tcdm_gnt,
    output logic [MP-1:0]        tcdm_r_valid,
    output logic [MP-1:0][31:0]  tcdm_r_data,
    output logic                 err_o
);

    // Virtual bank N_BANKS collects every out-of-range request.
    localparam int NV = N_BANKS + 1;
    localparam int PW = (MP > 1) ? $clog2(MP) : 1;
    localparam int BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int VW = $clog2(NV);
    localparam int RW = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam int CW = (STALL_EVERY > 0) ? $clog2(STALL_EVERY + 1) : 1;
    localparam logic [32:0] SPAN = 33'(N_BANKS) * 33'(BANK_WORDS) * 33'd4;

    logic [31:0]          mem [N_BANKS][BANK_WORDS];

    logic [MP-1:0][31:0]  offs;
    logic [MP-1:0]        in_range;
    logic [MP-1:0][BW-1:0] bank_sel;
    logic [MP-1:0][RW-1:0] row_sel;
    logic [MP-1:0][VW-1:0] vbank;
    logic [MP-1:0]        masked;
    logic [MP-1:0]        eligible;

    logic [PW-1:0]        rr [NV];
    logic [CW-1:0]        cnt [MP];
    logic [NV-1:0]        bank_any;
    logic [PW-1:0]        bank_win [NV];

    // Address decode. The subtraction wraps for addresses below the base, which
    // then fail the span comparison and land in the out-of-range virtual bank.
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            offs[p]     = tcdm_add[p] - BASE_ADDR;
            in_range[p] = {1'b0, offs[p]} < SPAN;
            bank_sel[p] = BW'((offs[p] >> 2) % 32'(N_BANKS));
            row_sel[p]  = RW'((offs[p] >> 2) / 32'(N_BANKS));
            vbank[p]    = in_range[p] ? VW'(bank_sel[p]) : VW'(N_BANKS);
            masked[p]   = (STALL_EVERY > 0) && (cnt[p] == CW'(STALL_EVERY));
        end
        eligible = tcdm_req & ~masked & {MP{rst_ni}};
    end

    // Round-robin search per virtual bank, starting at that bank's pointer.
    always_comb begin
        logic [PW-1:0] idx;
        bank_any = '0;
        for (int b = 0; b < NV; b++) begin
            bank_win[b] = '0;
            for (int k = 0; k < MP; k++) begin
                idx = PW'((int'(rr[b]) + k) % MP);
                if (!bank_any[b] && eligible[idx] && (vbank[idx] == VW'(b))) begin
                    bank_any[b] = 1'b1;
                    bank_win[b] = idx;
                end
            end
        end
    end

    // A port is granted when it is the winner of the bank it addresses.
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            tcdm_gnt[p] = eligible[p] && bank_any[vbank[p]] &&
                          (bank_win[vbank[p]] == PW'(p));
        end
    end

    // Memory array. Never reset; out-of-range writes are dropped.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            if (tcdm_gnt[p] && !tcdm_wen[p] && in_range[p]) begin
                for (int i = 0; i < 4; i++) begin
                    if (tcdm_be[p][i]) begin
                        mem[bank_sel[p]][row_sel[p]][8*i +: 8] <= tcdm_data[p][8*i +: 8];
                    end
                end
            end
        end
    end

    // Responses, sticky error, arbiter pointers and stall counters. The read
    // samples the array before this edge's writes land (read-before-write).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcdm_r_valid <= '0;
            tcdm_r_data  <= '0;
            err_o        <= 1'b0;
            rr           <= '{default: '0};
            cnt          <= '{default: '0};
        end else begin
            for (int p = 0; p < MP; p++) begin
                tcdm_r_valid[p] <= tcdm_gnt[p];
                if (tcdm_gnt[p] && tcdm_wen[p]) begin
                    tcdm_r_data[p] <= in_range[p] ? mem[bank_sel[p]][row_sel[p]] : 32'hDEAD_BEEF;
                end else begin
                    tcdm_r_data[p] <= 32'h0;
                end
            end

            if (clear_i) begin
                err_o <= 1'b0;
            end else if (|(tcdm_gnt & ~in_range)) begin
                err_o <= 1'b1;
            end

            for (int b = 0; b < NV; b++) begin
                if (clear_i) begin
                    rr[b] <= '0;
                end else if (bank_any[b]) begin
                    rr[b] <= (bank_win[b] == PW'(MP - 1)) ? '0 : bank_win[b] + PW'(1);
                end
            end

            // A full counter masks its port for one requesting cycle, then restarts.
            for (int p = 0; p < MP; p++) begin
                if (clear_i) begin
                    cnt[p] <= '0;
                end else if (STALL_EVERY > 0) begin
                    if (masked[p] && tcdm_req[p]) begin
                        cnt[p] <= '0;
                    end else if (tcdm_gnt[p]) begin
                        cnt[p] <= cnt[p] + CW'(1);
                    end
                end
            end
        end
    end

endmodule
